// File: rtl/bus_map_pkg.sv
// bus_map_pkg: memory map and STATUS layout shared by data_bus_responder and
// its FIFO.
//   Address constants : MMIO_BASE, CYCLE_ADDR, TX_DATA_ADDR, STATUS_ADDR
//   STATUS bit fields : ST_EMPTY, ST_FULL, ST_COUNT_LSB (ST_COUNT_W wide), ST_OVF
//   sel_e             : which target an address decodes to
//   status_word()     : packs the FIFO flags into a STATUS read value
package bus_map_pkg;

  localparam logic [31:0] MMIO_BASE    = 32'h8000_0000;
  localparam logic [31:0] CYCLE_ADDR   = MMIO_BASE + 32'h0;
  localparam logic [31:0] TX_DATA_ADDR = MMIO_BASE + 32'h4;
  localparam logic [31:0] STATUS_ADDR  = MMIO_BASE + 32'h8;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_COUNT_LSB = 2;
  localparam int ST_COUNT_W   = 3;
  localparam int ST_OVF       = 8;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_CYCLE,
    SEL_TX,
    SEL_STATUS
  } sel_e;

  function automatic logic [31:0] status_word(
    input logic                  empty,
    input logic                  full,
    input logic [ST_COUNT_W-1:0] count,
    input logic                  ovf
  );
    logic [31:0] w;
    w = '0;
    w[ST_EMPTY]                   = empty;
    w[ST_FULL]                    = full;
    w[ST_COUNT_LSB +: ST_COUNT_W] = count;
    w[ST_OVF]                     = ovf;
    return w;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: small circular byte FIFO feeding the transmit stream.
//   clk, reset : clock, synchronous active-high reset (pointers/count only)
//   push       : enqueue push_data (accepted when not full, or when a pop
//                happens on the same edge)
//   push_data  : byte to enqueue
//   pop        : dequeue request; ignored while empty
//   head       : oldest entry, forced to 0 while empty
//   count      : number of stored entries
//   empty/full : count == 0 / count == DEPTH
module byte_fifo
  import bus_map_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [7:0]            push_data,
  input  logic                  pop,
  output logic [7:0]            head,
  output logic [ST_COUNT_W-1:0] count,
  output logic                  empty,
  output logic                  full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]            r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [ST_COUNT_W-1:0] r_count;
  logic                  w_do_push;
  logic                  w_do_pop;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty = (r_count == '0);
  assign full  = (r_count == ST_COUNT_W'(DEPTH));
  assign count = r_count;

  // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  // Storage is never read while empty, so head is masked instead of clearing r_mem.
  assign head = empty ? 8'h00 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + ST_COUNT_W'(1);
        2'b01:   r_count <= r_count - ST_COUNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/data_bus_responder.sv
// data_bus_responder: data-port responder for the single-cycle core.
// Loads are combinational; stores commit on the rising edge.
//   clk, reset : clock, synchronous active-high reset
//   MemWrite   : store strobe
//   Addr       : byte address (core ALUResult)
//   WriteData  : store data
//   ReadData   : load data, combinational from Addr and current state
//   out_valid  : transmit FIFO head valid
//   out_data   : transmit FIFO head byte
//   out_ready  : sink accepts the head byte (pop on valid && ready)
// Map: RAM at 0x0000_0000 (RAM_WORDS words), CYCLE 0x8000_0000,
// TX_DATA 0x8000_0004 (write-only), STATUS 0x8000_0008. Other addresses read 0.
module data_bus_responder
  import bus_map_pkg::*;
#(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready
);

  localparam int RAM_AW = $clog2(RAM_WORDS);

  logic [31:0]           r_mem [RAM_WORDS];
  logic [31:0]           r_cycle;
  logic                  r_ovf;

  sel_e                  w_sel;
  logic [RAM_AW-1:0]     w_ram_idx;
  logic                  w_wr_ram;
  logic                  w_wr_cycle;
  logic                  w_tx_push;
  logic                  w_wr_status;
  logic [7:0]            w_head;
  logic [ST_COUNT_W-1:0] w_count;
  logic                  w_empty;
  logic                  w_full;

  // Address decode: RAM occupies the low half up to RAM_WORDS words; the
  // byte offset within a word is ignored there but MMIO needs exact addresses.
  always_comb begin
    w_sel = SEL_NONE;
    if (!Addr[31]) begin
      if (Addr[30:2] < 29'(RAM_WORDS)) w_sel = SEL_RAM;
    end else if (Addr == CYCLE_ADDR) begin
      w_sel = SEL_CYCLE;
    end else if (Addr == TX_DATA_ADDR) begin
      w_sel = SEL_TX;
    end else if (Addr == STATUS_ADDR) begin
      w_sel = SEL_STATUS;
    end
  end

  assign w_ram_idx   = Addr[RAM_AW+1:2];
  assign w_wr_ram    = MemWrite && (w_sel == SEL_RAM);
  assign w_wr_cycle  = MemWrite && (w_sel == SEL_CYCLE);
  assign w_tx_push   = MemWrite && (w_sel == SEL_TX);
  assign w_wr_status = MemWrite && (w_sel == SEL_STATUS);

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (w_wr_ram) begin
      r_mem[w_ram_idx] <= WriteData;
    end
  end

  // A store to CYCLE replaces that cycle's increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle <= '0;
    end else if (w_wr_cycle) begin
      r_cycle <= WriteData;
    end else begin
      r_cycle <= r_cycle + 32'd1;
    end
  end

  // A full FIFO pops whenever out_ready is high, so out_ready alone tells us
  // whether the incoming byte finds room.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (w_wr_status && WriteData[ST_OVF]) begin
      r_ovf <= 1'b0;
    end else if (w_tx_push && w_full && !out_ready) begin
      r_ovf <= 1'b1;
    end
  end

  byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_tx_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (w_tx_push),
    .push_data(WriteData[7:0]),
    .pop      (out_ready),
    .head     (w_head),
    .count    (w_count),
    .empty    (w_empty),
    .full     (w_full)
  );

  assign out_valid = !w_empty;
  assign out_data  = w_head;

  always_comb begin
    ReadData = '0;
    case (w_sel)
      SEL_RAM:    ReadData = r_mem[w_ram_idx];
      SEL_CYCLE:  ReadData = r_cycle;
      SEL_STATUS: ReadData = status_word(w_empty, w_full, w_count, r_ovf);
      default:    ReadData = '0;
    endcase
  end

endmodule
